// File: rtl/power_rail_seq.sv
`default_nettype none
// ============================================================================
// Module   : power_rail_seq
// Purpose  : Ordered power-rail sequencer. Rails come up in index order, and
//            each rail waits for its power-good before the next is enabled.
//            Rails go down in reverse order. A power-good timeout during ramp-up,
//            or a lost power-good, latches a fault. Timing uses the shared
//            8 Hz clock enable.
// Revision : 1.0 - initial release
// ============================================================================
module power_rail_seq #(
  parameter int         NUM_RAILS  = 4,     // legal range 2..8
  parameter logic [2:0] PG_TIMEOUT = 3'd2   // ce_8hz ticks before a wait expires
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce_8hz_i,
  input  logic                 pwr_enable_i,
  input  logic [NUM_RAILS-1:0] pg_i,
  input  logic                 fault_clr_i,
  output logic [NUM_RAILS-1:0] rail_en_o,
  output logic                 all_good_o,
  output logic                 fault_o,
  output logic [2:0]           fault_rail_o,
  output logic                 seq_busy_o
);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_ON        = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NUM_RAILS - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] timer_q, timer_d;
  logic [2:0] fault_rail_q, fault_rail_d;

  // Power-good of the rail currently addressed by idx, plus lowest-failing
  // indices both below idx (ramp-up check) and across all rails (ON check).
  logic       pg_cur;
  logic       low_fail_any;
  logic [2:0] low_fail_idx;
  logic       any_fail;
  logic [2:0] any_fail_idx;
  logic       expire;

  // Scan downwards so the last hit written is the lowest failing index.
  always_comb begin
    pg_cur       = 1'b0;
    low_fail_any = 1'b0;
    low_fail_idx = 3'd0;
    any_fail     = 1'b0;
    any_fail_idx = 3'd0;
    for (int j = NUM_RAILS - 1; j >= 0; j--) begin
      if (idx_q == 3'(j)) begin
        pg_cur = pg_i[j];
      end
      if (!pg_i[j]) begin
        any_fail     = 1'b1;
        any_fail_idx = 3'(j);
        if (3'(j) < idx_q) begin
          low_fail_any = 1'b1;
          low_fail_idx = 3'(j);
        end
      end
    end
  end

  // A wait expires on the tick that finds the timer already at its limit.
  assign expire = ce_8hz_i && (timer_q == PG_TIMEOUT);

  // Next-state, rail index, fault index and wait-timer selection.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    fault_rail_d = fault_rail_q;
    timer_d      = timer_q;

    case (state_q)
      ST_OFF: begin
        if (pwr_enable_i) begin
          state_d = ST_RAMP_UP;
          idx_d   = 3'd0;
        end
      end

      ST_RAMP_UP: begin
        if (low_fail_any) begin
          state_d      = ST_FAULT;
          fault_rail_d = low_fail_idx;
        end else if (!pwr_enable_i) begin
          // Abort: the current rail is dropped first, then unwind downwards.
          state_d = ST_RAMP_DOWN;
        end else if (pg_cur) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_ON;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else if (expire) begin
          state_d      = ST_FAULT;
          fault_rail_d = idx_q;
        end
      end

      ST_ON: begin
        if (any_fail) begin
          state_d      = ST_FAULT;
          fault_rail_d = any_fail_idx;
        end else if (!pwr_enable_i) begin
          state_d = ST_RAMP_DOWN;
          idx_d   = LAST_IDX;
        end
      end

      ST_RAMP_DOWN: begin
        // A rail that never drops its power-good is abandoned after the
        // timeout rather than faulted, so shutdown always completes.
        if (!pg_cur || expire) begin
          if (idx_q == 3'd0) begin
            state_d = ST_OFF;
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end
      end

      ST_FAULT: begin
        if (fault_clr_i && !pwr_enable_i) begin
          state_d      = ST_OFF;
          idx_d        = 3'd0;
          fault_rail_d = 3'd0;
        end
      end

      default: begin
        state_d      = ST_OFF;
        idx_d        = 3'd0;
        fault_rail_d = 3'd0;
      end
    endcase

    if ((state_d != state_q) || (idx_d != idx_q)) begin
      timer_d = 3'd0;
    end else if (((state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN)) && ce_8hz_i) begin
      timer_d = timer_q + 3'd1;
    end
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OFF;
      idx_q        <= 3'd0;
      timer_q      <= 3'd0;
      fault_rail_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      fault_rail_q <= fault_rail_d;
    end
  end

  // Rail enables: [idx:0] while ramping up, [idx-1:0] while ramping down.
  for (genvar g = 0; g < NUM_RAILS; g++) begin : g_rail_en
    assign rail_en_o[g] = (state_q == ST_ON)
                        | ((state_q == ST_RAMP_UP)   && (3'(g) <= idx_q))
                        | ((state_q == ST_RAMP_DOWN) && (3'(g) <  idx_q));
  end

  assign all_good_o   = (state_q == ST_ON);
  assign fault_o      = (state_q == ST_FAULT);
  assign fault_rail_o = fault_rail_q;
  assign seq_busy_o   = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);

endmodule
`default_nettype wire
